// File: rtl/riscv_fetch.sv
// Instruction-fetch front end: drives the ROM PC, buffers {pc, inst} pairs, hands them to decode.
// Optional performance counters are enabled with RISCV_FETCH_PERF_EN.
module riscv_fetch #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0,
    parameter int                     MEM_BYTES   = 4096,
    parameter int                     DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [WORD_LENGTH-1:0] imem_pc,
    input  logic [WORD_LENGTH-1:0] imem_inst,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_inst,
    output logic [WORD_LENGTH-1:0] out_pc,
    output logic                   fault
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    localparam int                     PW      = $clog2(DEPTH);
    localparam logic [PW:0]            FULL    = (PW+1)'(DEPTH);
    localparam logic [WORD_LENGTH-1:0] LAST_PC = WORD_LENGTH'(MEM_BYTES - 4);

    logic [WORD_LENGTH-1:0] fetch_pc;
    logic [WORD_LENGTH-1:0] mem_pc   [DEPTH];
    logic [WORD_LENGTH-1:0] mem_inst [DEPTH];
    logic [PW-1:0]          head, tail;
    logic [PW:0]            count;

    logic pop, redir, in_range, room, try_push, push;

    assign imem_pc   = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = mem_pc[head];
    assign out_inst  = mem_inst[head];

    assign pop      = out_valid & out_ready;
    // A faulted fetch unit ignores redirects entirely, so buffered entries keep draining.
    assign redir    = redirect_valid & ~fault;
    assign in_range = (fetch_pc <= LAST_PC);
    assign room     = (count != FULL) | pop;
    assign try_push = ~fault & ~redirect_valid & room;
    assign push     = try_push & in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fault    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (redir) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00)
                fault <= 1'b1;
        end else begin
            if (push) begin
                mem_pc[tail]   <= fetch_pc;
                mem_inst[tail] <= imem_inst;
                tail           <= tail + 1'b1;
                fetch_pc       <= fetch_pc + WORD_LENGTH'(4);
            end
            if (try_push && !in_range)
                fault <= 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

`ifdef RISCV_FETCH_PERF_EN
    logic stall_full;
    assign stall_full = ~fault & ~redirect_valid & in_range & (count == FULL) & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall_full)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
- Instruction-fetch initiator that drives the byte-addressed instruction ROM port (pc out, 32-bit little-endian inst back in the same cycle) and sits between that ROM and decode.
- Maintains the fetch PC and buffers fetched {pc, inst} pairs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles control-flow redirects and raises a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
- WORD_LENGTH, 32, width of PC and instruction words
- RESET_PC, 32'h0000_0000, fetch address after reset
- MEM_BYTES, 4096, ROM size in bytes; valid fetch addresses satisfy pc + 3 < MEM_BYTES
- DEPTH, 2, fetch buffer entries (power of two, ≥ 2)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- imem_pc  output  WORD_LENGTH  byte address driven to the instruction ROM
- imem_inst  input  WORD_LENGTH  ROM read data for imem_pc, combinational, same cycle
- redirect_valid  input  1  branch/jump taken; flush and restart fetch
- redirect_pc  input  WORD_LENGTH  new fetch address
- out_valid  output  1  buffer head valid
- out_ready  input  1  decode accepts head
- out_inst  output  WORD_LENGTH  head instruction
- out_pc  output  WORD_LENGTH  head instruction address
- fault  output  1  sticky fetch fault; fetch halted

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - fetch_pc = RESET_PC; count = 0; head/tail pointers = 0; fault = 0.
  - Outputs: out_valid = 0, out_inst = 0, out_pc = 0. Storage entries are cleared.
  - rst wins over every other input in the same cycle.
- imem_pc = fetch_pc (combinational). The ROM answers in the same cycle, so the captured inst always corresponds to imem_pc.
- pop = out_valid & out_ready.
- push is asserted when all of the following hold:
  - not rst
  - not fault
  - not redirect_valid
  - fetch address in range
  - either count < DEPTH, or (count == DEPTH and pop)
- On push:
  - Entry {fetch_pc, imem_inst} is written at tail.
  - fetch_pc <= fetch_pc + 4, modulo 2^WORD_LENGTH.
- count update:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: count unchanged
  - Full and popped: push allowed in the same cycle, so steady-state throughput is 1 instr/cycle.
- out_valid = (count != 0). out_inst/out_pc come from the head entry, registered storage only, with no combinational path from imem_inst.
- Latency: first cycle after rst deasserts pushes RESET_PC; out_valid rises the following cycle (1-cycle fetch-to-decode latency).
- Redirect (redirect_valid = 1):
  - Buffer flushed: count = 0, pointers reset.
  - No push that cycle.
  - A coincident pop is treated as accepted by decode, but the entry is discarded anyway.
  - fetch_pc <= redirect_pc.
  - Next cycle fetches redirect_pc; out_valid is 0 for exactly one cycle after redirect, assuming a valid target.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - Flush as above; fault <= 1; fetch_pc <= redirect_pc (kept for debug).
  - No further pushes; out_valid stays 0 until rst.
- Out-of-range fetch (fetch_pc > MEM_BYTES − 4), evaluated when a push would otherwise occur:
  - No push; fault <= 1.
  - Already-buffered entries still drain to decode normally.
- fault is sticky until rst. redirect_valid while fault = 1 is ignored; fetch_pc does not change.
- Stall: out_ready = 0 with a full buffer:
  - No push; fetch_pc holds.
  - imem_pc stable; head entry stable.

Optional Feature:
- Macro: RISCV_FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched[31:0], incremented on every push, and perf_stall[31:0], incremented each cycle push is blocked only because the buffer is full without pop.
  - Both counters reset to 0 on rst and wrap at 2^32.
  - Redirect cycles count in neither counter.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, out_ready = 1 always, ROM word at byte addr N = N:
  - out_pc sequence 0x0, 0x4, 0x8…, one per cycle from cycle 2.
  - out_inst == out_pc.
- out_ready = 0 for 5 cycles after first valid:
  - buffer fills to DEPTH = 2 (out_pc 0x0 held, count 2), imem_pc holds 0x8.
  - On release, 0x0, 0x4, 0x8 appear back-to-back with no bubble.
- redirect_valid with redirect_pc = 0x100 while buffer full:
  - next cycle out_valid = 0.
  - following cycle out_pc = 0x100; no stale 0x0/0x4 ever presented.
- redirect_pc = 0x102:
  - fault = 1 next cycle; out_valid stays 0.
  - a later redirect to 0x200 is ignored.
  - rst clears fault and restarts at RESET_PC.
- MEM_BYTES = 16, sequential run from 0:
  - 0x0, 0x4, 0x8, 0xC delivered; fault asserts when fetch_pc = 0x10.
  - no entry with pc 0x10 delivered.
- rst asserted mid-stream with buffer full and redirect_valid = 1 in the same cycle:
  - next cycle out_valid = 0, imem_pc = RESET_PC, fault = 0.
  - (with RISCV_FETCH_PERF_EN) both counters = 0.
